seven_seg_mux: RTL and testbench

Time-multiplexed seven-segment display driver that consumes the packed BCD digit array produced by the decimal counter stage and drives a common-anode/cathode multi-digit display. It scans one digit per slot, decodes BCD to segments, inserts anode dead-time between digits to suppress ghosting, and snapshots its inputs once per frame so that a counter update mid-scan never tears the display.

---
 rtl/seven_seg_pkg.sv | 38 +++
 rtl/seven_seg_decode.sv | 15 +
 rtl/seven_seg_mux.sv | 177 +++++++++++++++++
 tb/tb_seven_seg_mux.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display blocks.
//   bcd_t       : one BCD digit
//   state_t     : scan FSM state (IDLE / BLANK / ON)
//   SEG_OFF     : all segments dark (active-high form)
//   SEG_DASH    : error glyph, segment g only (active-high form)
//   bcd_to_seg  : BCD -> {g,f,e,d,c,b,a}, active-high; 10..15 map to SEG_DASH
package seven_seg_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF  = 7'b0000000;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    function automatic logic [6:0] bcd_to_seg(input bcd_t bcd);
        logic [6:0] pattern;
        case (bcd)
            4'd0:    pattern = 7'b0111111;
            4'd1:    pattern = 7'b0000110;
            4'd2:    pattern = 7'b1011011;
            4'd3:    pattern = 7'b1001111;
            4'd4:    pattern = 7'b1100110;
            4'd5:    pattern = 7'b1101101;
            4'd6:    pattern = 7'b1111101;
            4'd7:    pattern = 7'b0000111;
            4'd8:    pattern = 7'b1111111;
            4'd9:    pattern = 7'b1101111;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational BCD-plus-point decoder, active-high outputs.
//   bcd   in  4  BCD digit (10..15 show a dash)
//   point in  1  decimal point request
//   glyph out 8  {dp, g, f, e, d, c, b, a}
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  bcd_t       bcd,
    input  logic       point,
    output logic [7:0] glyph
);

    assign glyph = {point, bcd_to_seg(bcd)};

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed seven-segment display driver.
// Scans one digit per REFRESH_DIV-cycle slot; the first BLANK_CYCLES of each
// slot keep every anode off (anti-ghosting). Inputs are snapshotted once per
// frame (on entry to digit 0) so a mid-scan update never tears the display.
// Optional feature macro: SEVEN_SEG_LZB_EN (leading-zero blanking).
// Ports:
//   clk      in   1         clock
//   reset    in   1         synchronous active-high reset
//   enable   in   1         scan enable; low forces display dark
//   bcds     in   4xDIGITS  BCD digits, index 0 = rightmost
//   dp_mask  in   DIGITS    decimal point per digit
//   seg      out  7         {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   dp       out  1         decimal point, polarity per SEG_ACTIVE_LOW
//   an       out  DIGITS    digit select, polarity per AN_ACTIVE_LOW
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  bcd_t              bcds [DIGITS],
    input  logic [DIGITS-1:0] dp_mask,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(DIGITS - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               snap_take;

    bcd_t               snap_reg [DIGITS];
    logic [DIGITS-1:0]  dp_snap_reg;

    logic [DIGITS-1:0]  an_reg, an_next;
    logic [6:0]         seg_reg, seg_next;
    logic               dp_reg, dp_next;

    logic [7:0]         glyph;
    logic [DIGITS-1:0]  suppress;

    // Per-digit snapshot registers, loaded together once per frame.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_snap
            always_ff @(posedge clk) begin
                if (reset) begin
                    snap_reg[gi]    <= '0;
                    dp_snap_reg[gi] <= 1'b0;
                end else if (snap_take) begin
                    snap_reg[gi]    <= bcds[gi];
                    dp_snap_reg[gi] <= dp_mask[gi];
                end
            end
        end
    endgenerate

`ifdef SEVEN_SEG_LZB_EN
    // Digit i>0 is hidden when it and every higher digit are zero with no
    // decimal point; each bit scans its own range of higher digits directly
    // rather than chaining through the neighbouring bit.
    always_comb begin
        suppress = '0;
        for (int i = 1; i < DIGITS; i++) begin
            suppress[i] = 1'b1;
            for (int j = i; j < DIGITS; j++) begin
                if (snap_reg[j] != 4'd0 || dp_snap_reg[j]) begin
                    suppress[i] = 1'b0;
                end
            end
        end
    end
`else
    assign suppress = '0;
`endif

    seven_seg_decode u_decode (
        .bcd   (snap_reg[idx_reg]),
        .point (dp_snap_reg[idx_reg]),
        .glyph (glyph)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        snap_take  = 1'b0;

        if (!enable) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            idx_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    idx_next   = '0;
                    snap_take  = 1'b1;
                end
                ST_BLANK: begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_BLANK_LAST) begin
                        state_next = ST_ON;
                    end
                end
                ST_ON: begin
                    if (cnt_reg == CNT_SLOT_LAST) begin
                        state_next = ST_BLANK;
                        cnt_next   = '0;
                        if (idx_reg == IDX_LAST) begin
                            idx_next  = '0;
                            snap_take = 1'b1;   // new frame starts at digit 0
                        end else begin
                            idx_next = idx_reg + IDX_W'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            endcase
        end

        // Outputs follow the next state so they change on the same edge.
        // idx never changes on an edge that lands in ON, so the current
        // snapshot entry is the one being shown.
        an_next  = '0;
        seg_next = SEG_OFF;
        dp_next  = 1'b0;
        if (state_next == ST_ON && !suppress[idx_reg]) begin
            an_next[idx_reg] = 1'b1;
            seg_next         = glyph[6:0];
            dp_next          = glyph[7];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            an_reg    <= '0;
            seg_reg   <= SEG_OFF;
            dp_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            an_reg    <= an_next;
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
        end
    end

    assign seg = SEG_ACTIVE_LOW ? ~seg_reg : seg_reg;
    assign dp  = SEG_ACTIVE_LOW ? ~dp_reg  : dp_reg;
    assign an  = AN_ACTIVE_LOW  ? ~an_reg  : an_reg;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Self-checking bench for seven_seg_mux (DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2, active-low outputs). A timeline model predicts the
// outputs after every clock edge and queues them; a monitor pops and compares.
module tb_seven_seg_mux;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    typedef struct packed {
        logic [ND-1:0] an;
        logic          dp;
        logic [6:0]    seg;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [3:0]    bcds [ND];
    logic [ND-1:0] dp_mask;
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] an;

    int n_compared;
    int n_mismatched;

    exp_t exp_q [$];

    // Active-high reference glyphs {g,f,e,d,c,b,a}; 10..15 are the dash.
    logic [6:0] glyph_tbl [16];

    // Timeline model state: m_t counts edges since the enabling edge.
    bit         m_run;
    int         m_t;
    logic [3:0] m_snap [ND];
    logic [ND-1:0] m_dps;

    seven_seg_mux #(
        .DIGITS         (ND),
        .REFRESH_DIV    (RD),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .bcds    (bcds),
        .dp_mask (dp_mask),
        .seg     (seg),
        .dp      (dp),
        .an      (an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        glyph_tbl[0] = 7'h3F; glyph_tbl[1] = 7'h06; glyph_tbl[2] = 7'h5B;
        glyph_tbl[3] = 7'h4F; glyph_tbl[4] = 7'h66; glyph_tbl[5] = 7'h6D;
        glyph_tbl[6] = 7'h7D; glyph_tbl[7] = 7'h07; glyph_tbl[8] = 7'h7F;
        glyph_tbl[9] = 7'h6F;
        for (int i = 10; i < 16; i++) glyph_tbl[i] = 7'h40;
    end

    function automatic bit hidden(input int d);
        bit h;
        h = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
        if (d > 0) begin
            h = 1'b1;
            for (int j = d; j < ND; j++)
                if (m_snap[j] != 4'd0 || m_dps[j]) h = 1'b0;
        end
`endif
        return h;
    endfunction

    // Reference model: each edge, decide where the scan is in its frame.
    initial begin
        exp_t e;
        int   p, d, w;
        m_run = 1'b0;
        m_t   = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_run = 1'b0;
                m_t   = 0;
                for (int i = 0; i < ND; i++) m_snap[i] = 4'd0;
                m_dps = '0;
            end else if (!enable) begin
                m_run = 1'b0;
                m_t   = 0;
            end else if (!m_run) begin
                m_run = 1'b1;
                m_t   = 0;
                for (int i = 0; i < ND; i++) m_snap[i] = bcds[i];
                m_dps = dp_mask;
            end else begin
                m_t = m_t + 1;
                if (m_t % FRAME == 0) begin
                    for (int i = 0; i < ND; i++) m_snap[i] = bcds[i];
                    m_dps = dp_mask;
                end
            end
            e = '0;
            if (m_run) begin
                p = m_t % FRAME;
                d = p / RD;
                w = p % RD;
                if (w >= BC && !hidden(d)) begin
                    e.an[d] = 1'b1;
                    e.seg   = glyph_tbl[m_snap[d]];
                    e.dp    = m_dps[d];
                end
            end
            e.an  = ~e.an;
            e.seg = ~e.seg;
            e.dp  = ~e.dp;
            exp_q.push_back(e);
        end
    end

    // Monitor: compare DUT outputs mid-cycle against the queued prediction.
    initial begin
        exp_t e;
        n_compared   = 0;
        n_mismatched = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_compared++;
                if ({an, dp, seg} !== {e.an, e.dp, e.seg}) begin
                    n_mismatched++;
                    $display("FAIL outputs t=%0t an=%b dp=%b seg=%b expected an=%b dp=%b seg=%b",
                             $time, an, dp, seg, e.an, e.dp, e.seg);
                end
                n_compared++;
                if ($countones(~an) > 1) begin
                    n_mismatched++;
                    $display("FAIL one_anode t=%0t an=%b expected at most one low bit",
                             $time, an);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_bcds(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
        bcds[3] = d3; bcds[2] = d2; bcds[1] = d1; bcds[0] = d0;
    endtask

    // Bounded wait until the model reaches a given frame position.
    task automatic wait_pos(input int pos, input string tag);
        int k;
        k = 0;
        while (!(m_run && (m_t % FRAME) == pos) && k < 4 * FRAME) begin
            @(negedge clk);
            k++;
        end
        n_compared++;
        if (!(m_run && (m_t % FRAME) == pos)) begin
            n_mismatched++;
            $display("FAIL wait_%s position=%0d expected %0d within %0d cycles",
                     tag, m_t % FRAME, pos, 4 * FRAME);
        end
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        dp_mask = '0;
        set_bcds(4'd0, 4'd0, 4'd0, 4'd0);
        tick(3);
        reset = 1'b0;
        tick(2);
        $display("phase reset: done at %0t", $time);

        set_bcds(4'd1, 4'd2, 4'd3, 4'd4);
        enable = 1'b1;
        tick(40);
        $display("phase scan_1234: done at %0t", $time);

        wait_pos(RD + 4, "digit1");
        set_bcds(4'd5, 4'd6, 4'd7, 4'd8);
        tick(70);
        $display("phase midframe_change: done at %0t", $time);

        bcds[2] = 4'hB;
        dp_mask = 4'b0010;
        tick(70);
        $display("phase dash_glyph: done at %0t", $time);

        wait_pos(2 * RD + 3, "digit2_on");
        enable = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(40);
        $display("phase enable_drop: done at %0t", $time);

        tick(13);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(40);
        $display("phase reset_midscan: done at %0t", $time);

        set_bcds(4'd0, 4'd0, 4'd0, 4'd7);
        dp_mask = 4'b0000;
        tick(70);
        dp_mask = 4'b0100;
        tick(70);
        $display("phase leading_zeros: done at %0t", $time);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 3)
                set_bcds(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 99) < 2)
                dp_mask = 4'($urandom_range(0, 15));
            if (enable && $urandom_range(0, 299) == 0)
                enable = 1'b0;
            else if (!enable && $urandom_range(0, 7) == 0)
                enable = 1'b1;
            reset = ($urandom_range(0, 799) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(2);
        $display("phase random: done at %0t", $time);

        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
